// File: rtl/gate_pkg.sv
// Shared definitions for the gate-sharing arbiter: opcodes and FSM states.
package gate_pkg;

    // Bitwise gate opcodes presented by each requester
    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    // Sequencer states: IDLE arbitrates and latches, EVAL produces the result
    typedef enum logic {
        S_IDLE = 1'b0,
        S_EVAL = 1'b1
    } state_t;

endpackage

// File: rtl/gate_unit.sv
// Shared combinational 2-input gate evaluated bitwise over W bits.
module gate_unit #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] y
);
    import gate_pkg::*;

    // Select the gate function addressed by the opcode
    always_comb begin
        y = a | b;
        case (op)
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            default: y = a | b;
        endcase
    end

endmodule

// File: rtl/gate_share_arbiter.sv
// Round-robin arbiter that time-shares one gate_unit among NREQ requesters.
// A grant latches the winner's operands; the following cycle registers the
// gate result tagged with the winner's index.
module gate_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 1,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    input  logic [NREQ*2-1:0] op_in,
    output logic [NREQ-1:0]   gnt,
    output logic              done,
    output logic [W-1:0]      y,
    output logic [IDW-1:0]    y_id
);
    import gate_pkg::*;

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    win_q, win_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              done_q, done_d;
    logic [W-1:0]      y_q, y_d;
    logic [IDW-1:0]    y_id_q, y_id_d;

    logic [IDW-1:0]    pick;
    logic [W-1:0]      gate_y;

    // First set request scanning upward from p, wrapping at NREQ-1
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDW-1:0]  p);
        logic [IDW-1:0] win;
        logic [IDW-1:0] idx;
        logic           found;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(p) + k) % NREQ);
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign pick = rr_pick(req, ptr_q);

    gate_unit #(.W(W)) u_gate (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (gate_y)
    );

    // Next-state logic: arbitrate and latch in IDLE, publish result in EVAL
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        gnt_d   = '0;
        done_d  = 1'b0;
        y_d     = y_q;
        y_id_d  = y_id_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    win_d       = pick;
                    a_d         = a_in[pick*W +: W];
                    b_d         = b_in[pick*W +: W];
                    op_d        = op_in[pick*2 +: 2];
                    gnt_d[pick] = 1'b1;
                    ptr_d       = IDW'((int'(pick) + 1) % NREQ);
                    state_d     = S_EVAL;
                end
            end
            S_EVAL: begin
                y_d     = gate_y;
                y_id_d  = win_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            gnt_q   <= '0;
            done_q  <= 1'b0;
            y_q     <= '0;
            y_id_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            y_q     <= y_d;
            y_id_q  <= y_id_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign y    = y_q;
    assign y_id = y_id_q;

endmodule

// File: tb/tb_gate_share_arbiter.sv
// Self-checking bench for gate_share_arbiter (NREQ=4, W=4): directed table,
// multi-cycle corner sequences, and randomized transactions vs. a model.
module tb_gate_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ*2-1:0] op_in;
    logic [NREQ-1:0]   gnt;
    logic              done;
    logic [W-1:0]      y;
    logic [IDW-1:0]    y_id;

    int nvec  = 0;
    int nfail = 0;
    int m_ptr = 0;

    gate_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .a_in  (a_in),
        .b_in  (b_in),
        .op_in (op_in),
        .gnt   (gnt),
        .done  (done),
        .y     (y),
        .y_id  (y_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  op;
        logic [3:0]  gnt;
        logic [3:0]  y;
        logic [1:0]  id;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference gate, straight from the opcode table
    function automatic logic [3:0] gate_ref(input logic [3:0] a, input logic [3:0] b,
                                            input logic [1:0] op);
        case (op)
            2'd0:    return a | b;
            2'd1:    return a & b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Reference round-robin: first requesting index at or after ptr, wrapping
    function automatic int rr_ref(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        a_in  = 16'($urandom);
        b_in  = 16'($urandom);
        op_in = 8'($urandom);
        req   = 4'($urandom);
    endtask

    // One full grant/evaluate transaction starting from an IDLE sample edge
    task automatic do_txn(input string tag, input logic [3:0] r, input logic [15:0] a,
                          input logic [15:0] b, input logic [7:0] op, input logic [3:0] eg,
                          input logic [3:0] ey, input logic [1:0] eid);
        req = r; a_in = a; b_in = b; op_in = op;
        tick();
        check({tag, " gnt"}, 32'(gnt), 32'(eg));
        check({tag, " done_low"}, 32'(done), 32'd0);
        scramble();
        tick();
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " y"}, 32'(y), 32'(ey));
        check({tag, " y_id"}, 32'(y_id), 32'(eid));
        check({tag, " gnt_clear"}, 32'(gnt), 32'd0);
        $display("%s: req=%b gnt_exp=%b y=%h y_id=%0d", tag, r, eg, y, y_id);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Directed table; ptr carries from one row to the next (starts at 0)
        tbl[0]  = '{4'b0001, 16'h0000, 16'h0001, 8'h00, 4'b0001, 4'h1, 2'd0};
        tbl[1]  = '{4'b0100, 16'h0000, 16'h0000, 8'h00, 4'b0100, 4'h0, 2'd2};
        tbl[2]  = '{4'b0100, 16'h0000, 16'h0100, 8'h00, 4'b0100, 4'h1, 2'd2};
        tbl[3]  = '{4'b0100, 16'h0100, 16'h0000, 8'h00, 4'b0100, 4'h1, 2'd2};
        tbl[4]  = '{4'b0100, 16'h0100, 16'h0100, 8'h00, 4'b0100, 4'h1, 2'd2};
        tbl[5]  = '{4'b1001, 16'hC00F, 16'hA005, 8'h81, 4'b1000, 4'h6, 2'd3};
        tbl[6]  = '{4'b1001, 16'hC00F, 16'hA005, 8'h81, 4'b0001, 4'h5, 2'd0};
        tbl[7]  = '{4'b0010, 16'h00C0, 16'h00A0, 8'h00, 4'b0010, 4'hE, 2'd1};
        tbl[8]  = '{4'b0010, 16'h00C0, 16'h00A0, 8'h04, 4'b0010, 4'h8, 2'd1};
        tbl[9]  = '{4'b0010, 16'h00C0, 16'h00A0, 8'h08, 4'b0010, 4'h6, 2'd1};
        tbl[10] = '{4'b0010, 16'h00C0, 16'h00A0, 8'h0C, 4'b0010, 4'h1, 2'd1};

        rst = 1'b1; req = '0; a_in = '0; b_in = '0; op_in = '0;
        tick();
        tick();
        check("reset gnt", 32'(gnt), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset y", 32'(y), 32'd0);
        check("reset y_id", 32'(y_id), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++)
            do_txn($sformatf("table%0d", i), tbl[i].req, tbl[i].a, tbl[i].b,
                   tbl[i].op, tbl[i].gnt, tbl[i].y, tbl[i].id);

        // All four request from reset; each drops req after its grant
        rst = 1'b1; req = 4'b1111;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            logic [3:0]  ey;
            logic [3:0]  rr;
            logic [15:0] av, bv;
            logic [7:0]  ov;
            av = 16'($urandom); bv = 16'($urandom); ov = 8'($urandom);
            a_in = av; b_in = bv; op_in = ov;
            ey = gate_ref(av[k*4 +: 4], bv[k*4 +: 4], ov[k*2 +: 2]);
            tick();
            check($sformatf("all4 gnt%0d", k), 32'(gnt), 32'(1 << k));
            rr = req;
            rr[k] = 1'b0;
            req = rr;
            a_in = 16'($urandom); b_in = 16'($urandom); op_in = 8'($urandom);
            tick();
            check($sformatf("all4 done%0d", k), 32'(done), 32'd1);
            check($sformatf("all4 y%0d", k), 32'(y), 32'(ey));
            check($sformatf("all4 y_id%0d", k), 32'(y_id), 32'(k));
            $display("all4 step %0d: y=%h y_id=%0d", k, y, y_id);
        end

        // Reset in the EVAL cycle drops the operation and rewinds ptr
        do_txn("premove", 4'b0010, 16'h00F0, 16'h0000, 8'h00, 4'b0010, 4'hF, 2'd1);
        req = 4'b1111;
        tick();
        check("midrst gnt", 32'(gnt), 32'b0100);
        rst = 1'b1;
        tick();
        check("midrst done", 32'(done), 32'd0);
        check("midrst gnt_clear", 32'(gnt), 32'd0);
        check("midrst y", 32'(y), 32'd0);
        check("midrst y_id", 32'(y_id), 32'd0);
        $display("midrst: done=%0d y=%h y_id=%0d", done, y, y_id);
        rst = 1'b0;
        do_txn("postrst", 4'b1111, 16'h0003, 16'h0005, 8'h02, 4'b0001, 4'h6, 2'd0);
        m_ptr = 1;

        // Randomized transactions against the round-robin model
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                req = '0;
                a_in = 16'($urandom); b_in = 16'($urandom); op_in = 8'($urandom);
                tick();
                check("idle gnt", 32'(gnt), 32'd0);
                check("idle done", 32'(done), 32'd0);
            end else begin
                logic [3:0]  r;
                logic [15:0] av, bv;
                logic [7:0]  ov;
                int          w;
                r  = 4'($urandom_range(1, 15));
                av = 16'($urandom); bv = 16'($urandom); ov = 8'($urandom);
                w  = rr_ref(r, m_ptr);
                do_txn($sformatf("rand%0d", t), r, av, bv, ov, 4'(1 << w),
                       gate_ref(av[w*4 +: 4], bv[w*4 +: 4], ov[w*2 +: 2]), 2'(w));
                m_ptr = (w + 1) % NREQ;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
